// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: legal {a..g} patterns for digits 0-9,
// the blank pattern and the BCD code reported for an unrecognised pattern.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b1111110;
  localparam seg7_t SEG_1     = 7'b0110000;
  localparam seg7_t SEG_2     = 7'b1101101;
  localparam seg7_t SEG_3     = 7'b1111001;
  localparam seg7_t SEG_4     = 7'b0110011;
  localparam seg7_t SEG_5     = 7'b1011011;
  localparam seg7_t SEG_6     = 7'b1011111;
  localparam seg7_t SEG_7     = 7'b1110000;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1111011;
  localparam seg7_t SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment to BCD decoder; any pattern outside the ten legal
// codes (including blank) yields BCD_INVALID with the error flag set.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg7_t      seg_i,
  output logic       err_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    err_o = 1'b0;
    bcd_o = 4'd0;
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: begin
        err_o = 1'b1;
        bcd_o = BCD_INVALID;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a multiplexed 7-segment bus: each digit is captured
// once its pattern has been stable long enough, and whole frames go out on valid/ready.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_overrun
);

  localparam int         SW         = NUM_DIGITS + 7;
  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CNT);

  logic [SW-1:0]               prev_q;
  logic [7:0]                  run_q, run_d;
  logic [NUM_DIGITS-1:0][4:0]  shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]       seen_q, seen_d;
  logic                        drop_q, drop_d;
  logic [4*NUM_DIGITS-1:0]     bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]       err_q, err_d;
  logic                        valid_q, valid_d;
  logic                        ovr_q, ovr_d;

  logic [SW-1:0] sample;
  logic          oneHot;
  logic          capture;
  logic          decErr;
  logic [3:0]    decBcd;

  assign sample = {dig_en, seg_in};
  assign oneHot = $onehot(dig_en);

  seg7_pattern_decode u_decode (
    .seg_i (seg_in),
    .err_o (decErr),
    .bcd_o (decBcd)
  );

  // Saturating run length of identical one-hot samples; anything else restarts it.
  always_comb begin
    run_d = 8'd0;
    if (oneHot) begin
      if (sample == prev_q) run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
      else                  run_d = 8'd1;
    end
  end

  // The run_q check keeps a saturated run at 255 from capturing every cycle.
  assign capture = (run_d == STABLE_LIM) && (run_q != STABLE_LIM);

  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    drop_d   = drop_q;
    bcd_d    = bcd_q;
    err_d    = err_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    if (valid_q && frame_ready) valid_d = 1'b0;

    if (&seen_q) begin
      seen_d = '0;
      if (!valid_q || frame_ready) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          bcd_d[4*i +: 4] = shadow_q[i][3:0];
          err_d[i]        = shadow_q[i][4];
        end
        valid_d = 1'b1;
        ovr_d   = drop_q;
        drop_d  = 1'b0;
      end else begin
        drop_d = 1'b1;
      end
    end

    // A capture in the completion cycle already belongs to the next frame.
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_en[i]) begin
          shadow_d[i] = {decErr, decBcd};
          seen_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      run_q    <= 8'd0;
      shadow_q <= '0;
      seen_q   <= '0;
      drop_q   <= 1'b0;
      bcd_q    <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      prev_q   <= sample;
      run_q    <= run_d;
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      drop_q   <= drop_d;
      bcd_q    <= bcd_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bcd_out       = bcd_q;
  assign err_out       = err_q;
  assign frame_valid   = valid_q;
  assign frame_overrun = ovr_q;

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Reads back a time-multiplexed 7-segment display bus and recovers the BCD digits it shows. It is the receive-side counterpart of the team's BCD-to-segment drivers, used for display self-check and loopback test. Each digit is sampled only after its segment pattern has been stable for a programmable number of cycles, then decoded to BCD or flagged as invalid. A complete frame of all digits is presented on a valid/ready handshake.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; range 1..8.
- STABLE_CNT, 3: consecutive identical samples required before capture; range 2..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment pattern {a,b,c,d,e,f,g}: bit 6 = a, bit 0 = g, active-high.
- dig_en  in  NUM_DIGITS  digit select, active-high, one-hot; bit i selects digit i.
- bcd_out  out  4*NUM_DIGITS  recovered digits; digit i is in bits [4i+3:4i].
- err_out  out  NUM_DIGITS  bit i set when the pattern captured for digit i is not one of the ten legal codes.
- frame_valid  out  1  bcd_out, err_out and frame_overrun hold a complete frame.
- frame_ready  in  1  consumer accepts the frame.
- frame_overrun  out  1  at least one completed frame was dropped before this frame was loaded.

## Operation
- Legal codes, as {a..g}: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- Any other pattern, including blank 0000000, decodes to bcd 4'hF with the error bit set.
- Sample register: {dig_en, seg_in} is registered every cycle into prev.
- Run counter, 8-bit, saturating:
  - increments when the current {dig_en, seg_in} equals prev and dig_en is exactly one-hot;
  - otherwise reloads to 1 if dig_en is one-hot, or to 0 if not.
- Capture: when the run counter reaches STABLE_CNT, the decoded {err, bcd} is written to shadow slot i and seen[i] is set.
- Capture happens once per dwell. A dwell longer than STABLE_CNT does not rewrite the slot.
- A later dwell on the same digit overwrites its shadow slot (last value wins).
- dig_en that is zero-hot or multi-hot captures nothing and breaks the run.
- Frame complete when seen is all ones. In the cycle after completion:
  - Output free (frame_valid=0, or frame_valid=1 with frame_ready=1): shadow is copied to bcd_out/err_out, frame_valid=1, frame_overrun = drop flag, drop flag cleared, seen cleared.
  - Output busy: frame dropped, drop flag set, seen cleared, outputs unchanged.
- Handshake:
  - transfer occurs when frame_valid and frame_ready are both 1 on a clock edge;
  - outputs are stable while frame_valid=1 and frame_ready=0;
  - frame_valid drops after the transfer unless a new frame loads on the same edge.
- Reset: bcd_out=0, err_out=0, frame_valid=0, frame_overrun=0; prev, run counter, shadow, seen and drop flag are all cleared. Asserting reset mid-dwell or mid-frame discards partial state.

## Timing
- Identical one-hot inputs sampled on edges k .. k+STABLE_CNT-1 write the shadow slot at edge k+STABLE_CNT-1.
- Last-digit capture at edge n gives frame_valid=1 after edge n+1.
- Back-to-back frames: a completion that coincides with a transfer loads without a bubble.
- No input synchronizer: seg_in and dig_en are synchronous to clk.

## Structure
- Package seg7_pkg:
  - localparams SEG_0..SEG_9 (7-bit patterns);
  - SEG_BLANK = 7'b0000000;
  - BCD_INVALID = 4'hF;
  - typedef seg7_t (logic [6:0]).
- Sub-module seg7_pattern_decode: combinational seg7_t to {err, bcd[3:0]}; reusable by other checkers.
- Top level holds the sample register, run counter, shadow/seen, drop flag and output registers.

## Test plan
- Stable scan (NUM_DIGITS=4, STABLE_CNT=3, each digit held 5 cycles) showing 1,2,3,4, ready=1 -> frame_valid pulses; bcd_out=16'h4321, err_out=0, frame_overrun=0.
- Dwell of 2 cycles on digit 0 then 4 cycles -> only the 4-cycle dwell captures; slot written at its 3rd sample.
- Digit 2 shows 0000000 and digit 3 shows 1000000 -> err_out=4'b1100, nibbles 2 and 3 = 4'hF.
- ready held 0 across two completed frames, then ready=1 -> first frame held stable, second dropped; the next loaded frame has frame_overrun=1.
- dig_en=4'b0011 glitch mid-dwell -> run restarts, no capture during the glitch.
- rst asserted after 3 of 4 digits are captured -> all outputs 0 at once; the next frame needs all 4 digits again.
